// File: rtl/wb_master_interface_pkg.sv
// Shared Wishbone definitions: the 2-bit transfer state encoding, the data word
// reported on a failed access, and the timeout counter width. Slave-side
// interfaces import this package as well.
package wb_master_interface_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'b00,
    StRequest = 2'b01,
    StWaitAck = 2'b10,
    StFinish  = 2'b11
  } wb_state_e;

  // Read data returned on bus error or timeout.
  localparam logic [31:0] WbErrorData = 32'hFFFF_FFFF;

  // Wide enough for any timeout limit in 1..255.
  localparam int unsigned TimeoutWidth = 8;

endpackage

// File: rtl/wb_timeout_counter.sv
// Timeout counter for one Wishbone transfer.
// Ports:
//   i_clk     - clock
//   i_rst     - asynchronous active-high reset, clears the count
//   i_clear   - synchronous clear, has priority over i_enable
//   i_enable  - count one cycle
//   i_limit   - number of enabled cycles allowed
//   o_expired - high in the enabled cycle whose increment makes the count reach i_limit
module wb_timeout_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clear,
  input  logic             i_enable,
  input  logic [WIDTH-1:0] i_limit,
  output logic             o_expired
);

  logic [WIDTH-1:0] r_count;
  logic [WIDTH:0]   w_count_inc;

  // One bit wider so a limit at the top of the range never wraps.
  assign w_count_inc = {1'b0, r_count} + {{WIDTH{1'b0}}, 1'b1};

  // Flags the edge at which the count reaches the limit, so the owner leaves
  // after exactly i_limit enabled cycles.
  assign o_expired = i_enable && (w_count_inc >= {1'b0, i_limit});

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= w_count_inc[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/wb_master_interface.sv
// Single-transfer, pipelined-mode Wishbone master bridging a simple core memory
// port onto the bus.
// Ports:
//   wb_clk_i, wb_rst_i        - clock, asynchronous active-high reset
//   mem_enable                - core request, held until mem_busy is low
//   mem_writeEnable           - 1 = write, 0 = read
//   mem_byteSelect            - byte lanes
//   mem_address               - byte address
//   mem_dataWrite             - write data
//   mem_dataRead, mem_error   - result, valid in the cycle mem_busy drops
//   mem_busy                  - access in progress (combinational)
//   wb_cyc_o .. wb_data_o     - Wishbone request outputs
//   wb_ack_i .. wb_data_i     - Wishbone response inputs
module wb_master_interface #(
  parameter int unsigned ADDRESS_WIDTH  = 28,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic                     mem_enable,
  input  logic                     mem_writeEnable,
  input  logic [3:0]               mem_byteSelect,
  input  logic [ADDRESS_WIDTH-1:0] mem_address,
  input  logic [31:0]              mem_dataWrite,
  output logic [31:0]              mem_dataRead,
  output logic                     mem_busy,
  output logic                     mem_error,
  output logic                     wb_cyc_o,
  output logic                     wb_stb_o,
  output logic                     wb_we_o,
  output logic [3:0]               wb_sel_o,
  output logic [ADDRESS_WIDTH-1:0] wb_adr_o,
  output logic [31:0]              wb_data_o,
  input  logic                     wb_ack_i,
  input  logic                     wb_stall_i,
  input  logic                     wb_error_i,
  input  logic [31:0]              wb_data_i
);

  import wb_master_interface_pkg::*;

  localparam logic [TimeoutWidth-1:0] TimeoutLimit = TimeoutWidth'(TIMEOUT_CYCLES);

  wb_state_e                r_state;
  wb_state_e                w_state_d;

  logic [ADDRESS_WIDTH-1:0] r_adr;
  logic [3:0]               r_sel;
  logic [31:0]              r_dat;
  logic                     r_we;
  logic [31:0]              r_data_read;
  logic                     r_error;

  logic                     w_load;
  logic                     w_cnt_clear;
  logic                     w_cnt_enable;
  logic                     w_expired;
  logic                     w_done_ack;
  logic                     w_done_err;

  wb_timeout_counter #(
    .WIDTH (TimeoutWidth)
  ) u_timeout (
    .i_clk     (wb_clk_i),
    .i_rst     (wb_rst_i),
    .i_clear   (w_cnt_clear),
    .i_enable  (w_cnt_enable),
    .i_limit   (TimeoutLimit),
    .o_expired (w_expired)
  );

  // Next state and completion decode.
  always_comb begin
    w_state_d    = r_state;
    w_load       = 1'b0;
    w_cnt_clear  = 1'b0;
    w_cnt_enable = 1'b0;
    w_done_ack   = 1'b0;
    w_done_err   = 1'b0;
    case (r_state)
      StIdle: begin
        if (mem_enable) begin
          w_load      = 1'b1;
          w_cnt_clear = 1'b1;
          w_state_d   = StRequest;
        end
      end
      StRequest: begin
        w_cnt_enable = 1'b1;
        // A response is only meaningful once the strobe has been accepted.
        // A real response in the last allowed cycle beats the timeout.
        if (!wb_stall_i && (wb_error_i || wb_ack_i)) begin
          w_done_err = wb_error_i;
          w_done_ack = !wb_error_i;
          w_state_d  = StFinish;
        end else if (w_expired) begin
          w_done_err = 1'b1;
          w_state_d  = StFinish;
        end else if (!wb_stall_i) begin
          w_state_d = StWaitAck;
        end
      end
      StWaitAck: begin
        w_cnt_enable = 1'b1;
        if (wb_error_i || wb_ack_i) begin
          w_done_err = wb_error_i;
          w_done_ack = !wb_error_i;
          w_state_d  = StFinish;
        end else if (w_expired) begin
          w_done_err = 1'b1;
          w_state_d  = StFinish;
        end
      end
      StFinish: begin
        w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Request fields are captured once so they stay stable through stalls.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_adr <= '0;
      r_sel <= '0;
      r_dat <= '0;
      r_we  <= 1'b0;
    end else if (w_load) begin
      r_adr <= mem_address;
      r_sel <= mem_byteSelect;
      r_dat <= mem_dataWrite;
      r_we  <= mem_writeEnable;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_data_read <= WbErrorData;
      r_error     <= 1'b0;
    end else if (w_done_err) begin
      r_data_read <= WbErrorData;
      r_error     <= 1'b1;
    end else if (w_done_ack) begin
      r_data_read <= r_we ? 32'h0 : wb_data_i;
      r_error     <= 1'b0;
    end
  end

  // Bus outputs decode straight from state, so reset drops the cycle at once.
  always_comb begin
    wb_cyc_o  = 1'b0;
    wb_stb_o  = 1'b0;
    wb_we_o   = 1'b0;
    wb_sel_o  = '0;
    wb_adr_o  = '0;
    wb_data_o = '0;
    case (r_state)
      StRequest: begin
        wb_cyc_o  = 1'b1;
        wb_stb_o  = 1'b1;
        wb_we_o   = r_we;
        wb_sel_o  = r_sel;
        wb_adr_o  = r_adr;
        wb_data_o = r_dat;
      end
      StWaitAck: begin
        wb_cyc_o  = 1'b1;
        wb_we_o   = r_we;
        wb_sel_o  = r_sel;
        wb_adr_o  = r_adr;
        wb_data_o = r_dat;
      end
      default: begin
      end
    endcase
  end

  assign mem_busy     = (r_state == StRequest) || (r_state == StWaitAck) ||
                        ((r_state == StIdle) && mem_enable);
  assign mem_dataRead = r_data_read;
  assign mem_error    = r_error;

endmodule

// File: tb/tb_wb_master_interface.sv
module tb_wb_master_interface;

  localparam int unsigned AW = 28;
  localparam int unsigned T  = 16;

  logic          wb_clk_i;
  logic          wb_rst_i;
  logic          mem_enable;
  logic          mem_writeEnable;
  logic [3:0]    mem_byteSelect;
  logic [AW-1:0] mem_address;
  logic [31:0]   mem_dataWrite;
  logic [31:0]   mem_dataRead;
  logic          mem_busy;
  logic          mem_error;
  logic          wb_cyc_o;
  logic          wb_stb_o;
  logic          wb_we_o;
  logic [3:0]    wb_sel_o;
  logic [AW-1:0] wb_adr_o;
  logic [31:0]   wb_data_o;
  logic          wb_ack_i;
  logic          wb_stall_i;
  logic          wb_error_i;
  logic [31:0]   wb_data_i;

  int errors = 0;
  int checks = 0;

  wb_master_interface #(
    .ADDRESS_WIDTH  (AW),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .wb_clk_i        (wb_clk_i),
    .wb_rst_i        (wb_rst_i),
    .mem_enable      (mem_enable),
    .mem_writeEnable (mem_writeEnable),
    .mem_byteSelect  (mem_byteSelect),
    .mem_address     (mem_address),
    .mem_dataWrite   (mem_dataWrite),
    .mem_dataRead    (mem_dataRead),
    .mem_busy        (mem_busy),
    .mem_error       (mem_error),
    .wb_cyc_o        (wb_cyc_o),
    .wb_stb_o        (wb_stb_o),
    .wb_we_o         (wb_we_o),
    .wb_sel_o        (wb_sel_o),
    .wb_adr_o        (wb_adr_o),
    .wb_data_o       (wb_data_o),
    .wb_ack_i        (wb_ack_i),
    .wb_stall_i      (wb_stall_i),
    .wb_error_i      (wb_error_i),
    .wb_data_i       (wb_data_i)
  );

  initial wb_clk_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  // kind: 0 = slave never answers, 1 = ack, 2 = error, 3 = ack and error.
  // stall: strobe cycles the slave stalls before accepting.
  // in_req: answer in the accepting strobe cycle; otherwise in WAIT_ACK cycle `delay`.
  typedef struct {
    logic          we;
    logic [3:0]    sel;
    logic [AW-1:0] adr;
    logic [31:0]   dat;
    int            stall;
    int            kind;
    logic          in_req;
    int            delay;
    logic [31:0]   rdata;
    logic          drop_en;
    int            exp_busy;
    int            exp_stb;
    logic          exp_err;
    logic [31:0]   exp_data;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [3:0] sel, input logic [AW-1:0] adr,
                              input logic [31:0] dat, input int stall, input int kind,
                              input logic in_req, input int delay, input logic [31:0] rdata,
                              input logic drop_en, input int eb, input int es, input logic ee,
                              input logic [31:0] ed);
    vec_t v;
    v.we = we; v.sel = sel; v.adr = adr; v.dat = dat; v.stall = stall; v.kind = kind;
    v.in_req = in_req; v.delay = delay; v.rdata = rdata; v.drop_en = drop_en;
    v.exp_busy = eb; v.exp_stb = es; v.exp_err = ee; v.exp_data = ed;
    return v;
  endfunction

  // Reference model: the response lands in bus cycle r (0-based from the first
  // strobe). It wins if it arrives within the T-cycle budget, otherwise the
  // access times out after exactly T bus cycles.
  function automatic vec_t predict(input vec_t vi);
    vec_t v;
    int   r;
    v = vi;
    if (v.kind == 0) r = 1000;
    else if (v.in_req) r = v.stall;
    else r = v.stall + 1 + v.delay;
    if (r < int'(T)) begin
      v.exp_busy = r + 1;
      v.exp_stb  = v.stall + 1;
      v.exp_err  = (v.kind >= 2);
      v.exp_data = v.exp_err ? 32'hFFFF_FFFF : (v.we ? 32'h0 : v.rdata);
    end else begin
      v.exp_busy = int'(T);
      v.exp_stb  = (v.stall + 1 < int'(T)) ? v.stall + 1 : int'(T);
      v.exp_err  = 1'b1;
      v.exp_data = 32'hFFFF_FFFF;
    end
    return v;
  endfunction

  task automatic slave_idle();
    wb_ack_i   = 1'b0;
    wb_error_i = 1'b0;
    wb_stall_i = 1'b0;
    wb_data_i  = $urandom();
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    int          busy_n = 0;
    int          stb_n = 0;
    int          edges = 0;
    int          wait_idx = 0;
    bit          fields_ok = 1'b1;
    bit          done = 1'b0;
    bit          fin_ok = 1'b0;
    logic        act_err = 1'b0;
    logic [31:0] act_data = '0;
    logic [1:0]  resp;
    @(negedge wb_clk_i);
    mem_enable      = 1'b1;
    mem_writeEnable = v.we;
    mem_byteSelect  = v.sel;
    mem_address     = v.adr;
    mem_dataWrite   = v.dat;
    slave_idle();
    #1;
    check({tag, ":busy_on_enable"}, 32'(mem_busy), 32'd1);
    for (int k = 0; k < 100 && !done; k++) begin
      if (edges > 0 && !mem_busy) begin
        done     = 1'b1;
        fin_ok   = !wb_cyc_o && !wb_stb_o && !wb_we_o && (wb_sel_o == 4'd0) &&
                   (wb_adr_o == '0) && (wb_data_o == 32'd0);
        act_err  = mem_error;
        act_data = mem_dataRead;
        mem_enable = 1'b0;
        slave_idle();
      end else begin
        resp = 2'b00;
        if (wb_cyc_o) busy_n++;
        if (wb_stb_o) begin
          stb_n++;
          if (wb_adr_o !== v.adr || wb_sel_o !== v.sel || wb_we_o !== v.we ||
              wb_data_o !== v.dat) fields_ok = 1'b0;
          wb_stall_i = (stb_n <= v.stall);
          if (v.in_req && stb_n == v.stall + 1) resp = 2'(v.kind);
        end else if (wb_cyc_o) begin
          wb_stall_i = 1'b0;
          if (!v.in_req && wait_idx == v.delay) resp = 2'(v.kind);
          wait_idx++;
        end else begin
          wb_stall_i = 1'b0;
        end
        wb_ack_i   = resp[0];
        wb_error_i = resp[1];
        wb_data_i  = resp[0] ? v.rdata : $urandom();
        @(posedge wb_clk_i);
        edges++;
        @(negedge wb_clk_i);
        if (v.drop_en) mem_enable = 1'b0;
        #1;
      end
    end
    if (!done) begin
      check({tag, ":completion_within_bound"}, 32'd0, 32'd1);
      mem_enable = 1'b0;
      slave_idle();
    end else begin
      check({tag, ":cyc_cycles"}, 32'(busy_n), 32'(v.exp_busy));
      check({tag, ":stb_cycles"}, 32'(stb_n), 32'(v.exp_stb));
      check({tag, ":latency_edges"}, 32'(edges), 32'(v.exp_busy + 1));
      check({tag, ":mem_error"}, 32'(act_err), 32'(v.exp_err));
      check({tag, ":mem_dataRead"}, act_data, v.exp_data);
      check({tag, ":fields_stable"}, 32'(fields_ok), 32'd1);
      check({tag, ":finish_bus_idle"}, 32'(fin_ok), 32'd1);
      @(negedge wb_clk_i);
      #1;
      check({tag, ":idle_after"}, {30'd0, mem_busy, wb_cyc_o}, 32'd0);
    end
  endtask

  vec_t tbl[10];
  vec_t rv;

  initial begin
    wb_rst_i        = 1'b1;
    mem_enable      = 1'b0;
    mem_writeEnable = 1'b0;
    mem_byteSelect  = 4'd0;
    mem_address     = '0;
    mem_dataWrite   = 32'd0;
    slave_idle();

    //        we    sel      adr        dat           st  k  inq   d   rdata         drop  busy stb err  data
    tbl[0] = mk(1'b0, 4'hF,  28'h000100, 32'h0,       0,  1, 1'b0, 0,  32'h12345678, 1'b0, 2,   1,  1'b0, 32'h12345678);
    tbl[1] = mk(1'b1, 4'h3,  28'h0000A4, 32'hCAFEF00D, 4, 1, 1'b0, 0,  32'h55AA55AA, 1'b0, 6,   5,  1'b0, 32'h0);
    tbl[2] = mk(1'b0, 4'hF,  28'h000200, 32'h0,       0,  0, 1'b0, 0,  32'h0,        1'b0, 16,  1,  1'b1, 32'hFFFFFFFF);
    tbl[3] = mk(1'b0, 4'hC,  28'h000300, 32'h0,       0,  3, 1'b0, 2,  32'h0BADBEEF, 1'b0, 4,   1,  1'b1, 32'hFFFFFFFF);
    tbl[4] = mk(1'b0, 4'h1,  28'h0ABCDE, 32'h0,       2,  1, 1'b1, 0,  32'hA5A5A5A5, 1'b1, 3,   3,  1'b0, 32'hA5A5A5A5);
    tbl[5] = mk(1'b1, 4'hF,  28'h000010, 32'h11111111, 0, 2, 1'b1, 0,  32'h0,        1'b0, 1,   1,  1'b1, 32'hFFFFFFFF);
    tbl[6] = mk(1'b1, 4'h8,  28'hFFFFFFC, 32'h22222222, 20, 0, 1'b0, 0, 32'h0,       1'b0, 16,  16, 1'b1, 32'hFFFFFFFF);
    tbl[7] = mk(1'b0, 4'hF,  28'h000400, 32'h0,       0,  1, 1'b0, 14, 32'h76543210, 1'b0, 16,  1,  1'b0, 32'h76543210);
    tbl[8] = mk(1'b0, 4'hF,  28'h000500, 32'h0,       0,  1, 1'b0, 15, 32'h76543210, 1'b0, 16,  1,  1'b1, 32'hFFFFFFFF);
    tbl[9] = mk(1'b1, 4'h6,  28'h000600, 32'h33333333, 0, 2, 1'b0, 1,  32'h0,        1'b1, 3,   1,  1'b1, 32'hFFFFFFFF);

    // Reset values, checked while reset is held and before any clock edge.
    #3;
    check("reset_cyc_stb_we", {29'd0, wb_cyc_o, wb_stb_o, wb_we_o}, 32'd0);
    check("reset_mem_error", 32'(mem_error), 32'd0);
    check("reset_mem_dataRead", mem_dataRead, 32'hFFFF_FFFF);
    check("reset_mem_busy", 32'(mem_busy), 32'd0);
    repeat (2) @(negedge wb_clk_i);
    wb_rst_i = 1'b0;

    for (int i = 0; i < 10; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

    // Reset pulsed between edges while waiting for an acknowledge.
    @(negedge wb_clk_i);
    mem_enable      = 1'b1;
    mem_writeEnable = 1'b0;
    mem_byteSelect  = 4'hF;
    mem_address     = 28'h000700;
    slave_idle();
    @(posedge wb_clk_i);
    @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    mem_enable = 1'b0;
    #1;
    check("rst_pulse:in_wait_ack", {30'd0, wb_cyc_o, wb_stb_o}, 32'd2);
    wb_rst_i = 1'b1;
    #1;
    check("rst_pulse:bus_dropped", {30'd0, wb_cyc_o, wb_stb_o}, 32'd0);
    check("rst_pulse:busy", 32'(mem_busy), 32'd0);
    check("rst_pulse:mem_error", 32'(mem_error), 32'd0);
    check("rst_pulse:mem_dataRead", mem_dataRead, 32'hFFFF_FFFF);
    #1;
    wb_rst_i = 1'b0;
    // A late acknowledge after the abandoned transfer must not be reported.
    @(negedge wb_clk_i);
    wb_ack_i  = 1'b1;
    wb_data_i = 32'hDEADDEAD;
    @(negedge wb_clk_i);
    slave_idle();
    #1;
    check("rst_pulse:no_stale_ack", {mem_dataRead[30:0], mem_error}, {31'h7FFF_FFFF, 1'b0});
    run_txn(tbl[0], "post_rst");

    for (int i = 0; i < 40; i++) begin
      int k;
      rv.we    = 1'($urandom_range(0, 1));
      rv.sel   = 4'($urandom());
      rv.adr   = AW'($urandom());
      rv.dat   = $urandom();
      rv.rdata = $urandom();
      rv.stall = ($urandom_range(0, 7) == 0) ? 20 : int'($urandom_range(0, 5));
      k        = int'($urandom_range(0, 9));
      rv.kind  = (k == 0) ? 0 : (k <= 6) ? 1 : (k <= 8) ? 2 : 3;
      rv.in_req  = ($urandom_range(0, 3) == 0);
      rv.delay   = ($urandom_range(0, 5) == 0) ? int'($urandom_range(10, 16))
                                               : int'($urandom_range(0, 3));
      rv.drop_en = 1'($urandom_range(0, 1));
      rv = predict(rv);
      run_txn(rv, $sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
